line_burst_adaptor: RTL and testbench

- Memory-side responder for the L2 cache's 256-bit line interface (line read/write, address, write data, one-cycle response).
- Converts each line request into a fixed-length burst of 64-bit beats on the physical memory bus.
- Collects read beats into a full line, and serialises write lines into beats.
- Sits between the L2 cache and physical memory. One outstanding request at a time.

---
 rtl/line_burst_adaptor_pkg.sv | 17 +
 rtl/line_burst_adaptor_if.sv | 57 +++++
 rtl/line_burst_adaptor.sv | 130 +++++++++++++
 tb/tb_line_burst_adaptor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and constants for the L2 line to memory burst adaptor.
// Holds the FSM state enum, line/beat geometry and default watchdog limit.
package line_burst_pkg;
  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } burst_state_t;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_WIDTH_DEF   = 256;
  localparam int BEAT_WIDTH_DEF   = 64;
  localparam int BEATS            = LINE_WIDTH_DEF / BEAT_WIDTH_DEF;
  localparam int BEAT_IDX_BITS    = $clog2(BEATS);
  localparam int TIMEOUT_DEF      = 1024;
endpackage

// File: rtl/line_burst_adaptor_if.sv
// Cache-side line interface and memory-side burst interface.
// line_err exists only when LINE_BURST_TIMEOUT_EN is defined.
interface line_if
  import line_burst_pkg::*;
#(
  parameter int LW = LINE_WIDTH_DEF
) ();
  logic          line_read;
  logic          line_write;
  logic [31:0]   line_address;
  logic [LW-1:0] line_wdata;
  logic [LW-1:0] line_rdata;
  logic          line_resp;
`ifdef LINE_BURST_TIMEOUT_EN
  logic          line_err;

  modport master (
    output line_read, line_write, line_address, line_wdata,
    input  line_rdata, line_resp, line_err
  );
  modport slave (
    input  line_read, line_write, line_address, line_wdata,
    output line_rdata, line_resp, line_err
  );
`else
  modport master (
    output line_read, line_write, line_address, line_wdata,
    input  line_rdata, line_resp
  );
  modport slave (
    input  line_read, line_write, line_address, line_wdata,
    output line_rdata, line_resp
  );
`endif
endinterface

interface burst_if
  import line_burst_pkg::*;
#(
  parameter int BW = BEAT_WIDTH_DEF
) ();
  logic [31:0]   burst_address;
  logic          burst_read;
  logic          burst_write;
  logic [BW-1:0] burst_wdata;
  logic [BW-1:0] burst_rdata;
  logic          burst_resp;

  modport master (
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );
  modport slave (
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Turns one L2 line request into a fixed burst of memory beats.
// Optional per-beat watchdog: define LINE_BURST_TIMEOUT_EN.
module line_burst_adaptor
  import line_burst_pkg::*;
#(
  parameter int LINE_WIDTH     = LINE_WIDTH_DEF,
  parameter int BEAT_WIDTH     = BEAT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic     clk,
  input  logic     rst,
  line_if.slave    line,
  burst_if.master  burst
);
  localparam int NB = LINE_WIDTH / BEAT_WIDTH;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  burst_state_t          r_state;
  burst_state_t          w_next;
  logic [KW-1:0]         r_k;
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  w_busy;
  logic                  w_last;
  logic                  w_beat;
  logic                  w_accept;
  logic                  w_tmo;
  int                    w_off;

  assign w_busy   = (r_state == READ) || (r_state == WRITE);
  assign w_last   = (r_k == KW'(NB - 1));
  assign w_beat   = w_busy && burst.burst_resp;
  assign w_accept = (r_state == IDLE) &&
                    (line.line_read || line.line_write);
  assign w_off    = int'(r_k) * BEAT_WIDTH;

`ifdef LINE_BURST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wdog;
  logic          r_err;

  assign w_tmo = w_busy && !burst.burst_resp &&
                 (r_wdog == WW'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every beat and on state entry; error sticks until next request
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept)
        r_err <= 1'b0;
      else if (w_tmo)
        r_err <= 1'b1;
      if (!w_busy || burst.burst_resp || w_tmo)
        r_wdog <= '0;
      else
        r_wdog <= r_wdog + WW'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state: write wins over read; burst ends on last beat or watchdog
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (line.line_write)
          w_next = WRITE;
        else if (line.line_read)
          w_next = READ;
      end
      READ, WRITE: begin
        if ((burst.burst_resp && w_last) || w_tmo)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch request, step beat index, deserialise read beats into the line
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_k     <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= {line.line_address[31:LINE_OFFSET_BITS],
                   {LINE_OFFSET_BITS{1'b0}}};
        if (line.line_write)
          r_wdata <= line.line_wdata;
      end
      if (w_beat)
        r_k <= r_k + KW'(1);
      else if (!w_busy)
        r_k <= '0;
      if (w_beat && (r_state == READ))
        r_rdata[w_off +: BEAT_WIDTH] <= burst.burst_rdata;
    end
  end

  // Outputs decoded from state; write beat selected by beat index
  always_comb begin
    burst.burst_read    = (r_state == READ);
    burst.burst_write   = (r_state == WRITE);
    burst.burst_address = r_addr;
    burst.burst_wdata   = '0;
    if (r_state == WRITE)
      burst.burst_wdata = r_wdata[w_off +: BEAT_WIDTH];
    line.line_rdata     = r_rdata;
    line.line_resp      = (r_state == DONE);
`ifdef LINE_BURST_TIMEOUT_EN
    line.line_err       = r_err;
`endif
  end
endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench for line_burst_adaptor with a beat-level memory model.
// Define LINE_BURST_TIMEOUT_EN to also cover the watchdog path.
module tb_line_burst_adaptor;
  import line_burst_pkg::*;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;
`ifdef LINE_BURST_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  typedef logic [LW-1:0] lw_t;
  typedef struct {
    bit  wr;
    lw_t line;
    bit  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_if  #(.LW(LW)) lif ();
  burst_if #(.BW(BW)) bif ();

  line_burst_adaptor #(
    .LINE_WIDTH     (LW),
    .BEAT_WIDTH     (BW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .line  (lif.slave),
    .burst (bif.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t            sb[$];
  logic [BW-1:0]   exp_w[$];
  logic [BW-1:0]   rd_beats[$];
  logic [31:0]     exp_addr = '0;
  lw_t             last_line = '0;
  int              gap = 0;
  bit              mute = 1'b0;
  bit              last_wr = 1'b0;
  int              beats = 0;

  task automatic chk(input string tag, input lw_t got, input lw_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Memory model: answers beats after `gap` idle cycles, checks write beats
  initial begin
    int wcnt;
    wcnt = 0;
    bif.burst_resp  = 1'b0;
    bif.burst_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bif.burst_resp = 1'b0;
      if (rst && (bif.burst_read || bif.burst_write)) begin
        last_wr = bif.burst_write;
        chk("excl", lw_t'(bif.burst_read && bif.burst_write), '0);
        if (bif.burst_write && exp_w.size() > 0)
          chk("wbeat", lw_t'(bif.burst_wdata), lw_t'(exp_w[0]));
        if (!mute) begin
          if (wcnt >= gap) begin
            wcnt = 0;
            beats++;
            bif.burst_resp = 1'b1;
            chk("baddr", lw_t'(bif.burst_address), lw_t'(exp_addr));
            if (bif.burst_write) begin
              if (exp_w.size() > 0)
                void'(exp_w.pop_front());
            end else if (rd_beats.size() > 0) begin
              bif.burst_rdata = rd_beats.pop_front();
            end else begin
              bif.burst_rdata = '0;
            end
          end else begin
            wcnt++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every line_resp
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (lif.line_resp) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", lw_t'(1), '0);
        end else begin
          e = sb.pop_front();
          chk("resp_kind", lw_t'(last_wr), lw_t'(e.wr));
          if (!e.wr)
            chk("rdata", lif.line_rdata, e.line);
`ifdef LINE_BURST_TIMEOUT_EN
          chk("err", lw_t'(lif.line_err), lw_t'(e.err));
`endif
        end
      end
    end
  end

  // One line transaction; caller is #1 after a posedge with DUT in IDLE
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input lw_t wl, input lw_t rl, input int exp_cyc);
    int cyc;
    int nresp;
    bit done;
    exp_addr = {addr[31:5], 5'b0};
    beats = 0;
    if (wr) begin
      for (int i = 0; i < NB; i++)
        exp_w.push_back(wl[i*BW +: BW]);
      sb.push_back('{wr: 1'b1, line: '0, err: 1'b0});
    end
    if (rd) begin
      for (int i = 0; i < NB; i++)
        rd_beats.push_back(rl[i*BW +: BW]);
      sb.push_back('{wr: 1'b0, line: rl, err: 1'b0});
      last_line = rl;
    end
    lif.line_read    = rd;
    lif.line_write   = wr;
    lif.line_address = addr;
    lif.line_wdata   = wl;
    cyc   = 0;
    nresp = 0;
    done  = 1'b0;
    while (cyc < 400 && !done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2 && !(rd && wr)) begin
        lif.line_address = ~addr;
        lif.line_wdata   = ~wl;
      end
      if (lif.line_resp) begin
        nresp++;
        if (nresp == 1 && exp_cyc > 0)
          chk("latency", lw_t'(cyc), lw_t'(exp_cyc));
        if (lif.line_read && lif.line_write) begin
          lif.line_write = 1'b0;
        end else begin
          lif.line_read  = 1'b0;
          lif.line_write = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (!done)
      chk("resp_wait", '0, lw_t'(1));
    @(posedge clk);
    #1;
    chk("resp_pulse", lw_t'(lif.line_resp), '0);
  endtask

  function automatic lw_t rnd_line();
    lw_t v;
    for (int j = 0; j < LW / 32; j++)
      v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    lw_t l1, l2;
    int  cnt;
    lif.line_read    = 1'b0;
    lif.line_write   = 1'b0;
    lif.line_address = '0;
    lif.line_wdata   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp",  lw_t'(lif.line_resp), '0);
    chk("rst_brd",   lw_t'(bif.burst_read), '0);
    chk("rst_bwr",   lw_t'(bif.burst_write), '0);
    chk("rst_baddr", lw_t'(bif.burst_address), '0);
    chk("rst_bwdat", lw_t'(bif.burst_wdata), '0);
    chk("rst_rdata", lif.line_rdata, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    gap = 0;
    txn(1'b1, 1'b0, 32'h0000_1234, '0, l1, 5);

    l2 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    gap = 2;
    txn(1'b0, 1'b1, 32'h0000_8040, l2, '0, NB * 3 + 1);

    gap = 0;
    txn(1'b1, 1'b1, 32'hABCD_00FF, rnd_line(), rnd_line(), 5);

    txn(1'b1, 1'b0, 32'h0000_2000, '0, rnd_line(), 5);
    txn(1'b1, 1'b0, 32'h0000_2020, '0, rnd_line(), 5);

    exp_addr = 32'h0000_4000;
    beats = 0;
    l1 = rnd_line();
    for (int i = 0; i < NB; i++)
      rd_beats.push_back(l1[i*BW +: BW]);
    lif.line_address = 32'h0000_401F;
    lif.line_read    = 1'b1;
    cnt = 0;
    while (beats < 2 && cnt < 50) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    if (beats < 2)
      chk("mid_wait", '0, lw_t'(1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lif.line_read = 1'b0;
    @(negedge clk);
    chk("mid_resp",  lw_t'(lif.line_resp), '0);
    chk("mid_brd",   lw_t'(bif.burst_read), '0);
    chk("mid_baddr", lw_t'(bif.burst_address), '0);
    chk("mid_rdata", lif.line_rdata, '0);
    rst = 1'b1;
    rd_beats.delete();
    exp_w.delete();
    @(posedge clk);
    #1;
    txn(1'b1, 1'b0, 32'h0000_4000, '0, rnd_line(), 5);

    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, 3);
      if (i[0])
        txn(1'b1, 1'b0, $urandom, '0, rnd_line(), NB * (gap + 1) + 1);
      else
        txn(1'b0, 1'b1, $urandom, rnd_line(), '0, NB * (gap + 1) + 1);
    end
    gap = 0;

`ifdef LINE_BURST_TIMEOUT_EN
    mute = 1'b1;
    exp_addr = 32'h0000_6000;
    sb.push_back('{wr: 1'b0, line: last_line, err: 1'b1});
    lif.line_address = 32'h0000_6000;
    lif.line_read = 1'b1;
    cnt = 0;
    while (!lif.line_resp && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("tmo_latency", lw_t'(cnt), lw_t'(TMO + 1));
    lif.line_read = 1'b0;
    mute = 1'b0;
    @(posedge clk);
    #1;
    chk("tmo_err_hold", lw_t'(lif.line_err), lw_t'(1));
    txn(1'b1, 1'b0, 32'h0000_6000, '0, rnd_line(), 5);
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", lw_t'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
